// File: rtl/dram_read_responder.sv
// Services sample-read requests in the DRAM-controller clock domain: issues in-order read
// commands and streams each returned word out tagged with its request's period and tlast.
module dram_read_responder #(
    parameter int unsigned DATA_WIDTH      = 128,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               in_axis_tvalid,
    output logic                               in_axis_tready,
    input  logic [39:0]                        in_axis_tdata,
    input  logic                               in_axis_tlast,

    output logic                               mem_cmd_valid,
    input  logic                               mem_cmd_ready,
    output logic [23:0]                        mem_cmd_addr,

    input  logic                               mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]              mem_rsp_data,

    output logic                               out_axis_tvalid,
    input  logic                               out_axis_tready,
    output logic [DATA_WIDTH-1:0]              out_axis_tdata,
    output logic [13:0]                        out_axis_tuser,
    output logic                               out_axis_tlast,

    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               rsp_overflow
);

    localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] One    = CW'(1);

    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic                  cmd_valid_q;
    logic [23:0]           cmd_addr_q;
    logic [CW-1:0]         meta_wr_q;
    logic [CW-1:0]         data_wr_q;
    logic [CW-1:0]         rd_q;
    logic                  overflow_q;

    logic [DATA_WIDTH-1:0] data_mem [MAX_OUTSTANDING];
    logic [14:0]           meta_mem [MAX_OUTSTANDING];

    logic                  in_hs;
    logic                  out_hs;
    logic                  rsp_push;
    logic [CW-1:0]         data_count;
    logic [CW-1:0]         rsp_pending;
    logic                  unused_tdata_bits;

    assign unused_tdata_bits = ^in_axis_tdata[39:38];

    // Meta and data FIFOs always pop together, so they share one read pointer.
    assign data_count  = data_wr_q - rd_q;
    assign rsp_pending = outstanding_q - data_count - CW'(cmd_valid_q);

    assign in_axis_tready  = !rst && (outstanding_q < MaxCnt) && (!cmd_valid_q || mem_cmd_ready);
    assign in_hs           = in_axis_tvalid && in_axis_tready;
    assign out_axis_tvalid = (data_count != '0);
    assign out_hs          = out_axis_tvalid && out_axis_tready;
    assign rsp_push        = mem_rsp_valid && (rsp_pending != '0);

    assign mem_cmd_valid = cmd_valid_q;
    assign mem_cmd_addr  = cmd_addr_q;
    assign outstanding   = outstanding_q;
    assign rsp_overflow  = overflow_q;

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({in_hs, out_hs})
            2'b10:   outstanding_d = outstanding_q + One;
            2'b01:   outstanding_d = outstanding_q - One;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_addr_q    <= '0;
            meta_wr_q     <= '0;
            data_wr_q     <= '0;
            rd_q          <= '0;
            overflow_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            if (in_hs) begin
                cmd_valid_q <= 1'b1;
                cmd_addr_q  <= in_axis_tdata[23:0];
                meta_wr_q   <= meta_wr_q + One;
            end else if (mem_cmd_ready) begin
                cmd_valid_q <= 1'b0;
            end
            if (rsp_push) begin
                data_wr_q <= data_wr_q + One;
            end
            if (out_hs) begin
                rd_q <= rd_q + One;
            end
            // A word with no pending read behind it is dropped and flagged.
            if (mem_rsp_valid && !rsp_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            meta_mem[meta_wr_q[AW-1:0]] <= {in_axis_tlast, in_axis_tdata[37:24]};
        end
        if (rsp_push) begin
            data_mem[data_wr_q[AW-1:0]] <= mem_rsp_data;
        end
    end

    always_comb begin
        out_axis_tdata = '0;
        out_axis_tuser = '0;
        out_axis_tlast = 1'b0;
        if (out_axis_tvalid) begin
            out_axis_tdata                   = data_mem[rd_q[AW-1:0]];
            {out_axis_tlast, out_axis_tuser} = meta_mem[rd_q[AW-1:0]];
        end
    end

endmodule
